// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: byte-wide fetch, little-endian assembly, and a DEPTH-entry
// instruction/PC queue with flush redirect and credit-based request throttling.
module if_prefetch_queue #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    localparam int               INST_W     = 8 * INST_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_data_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [ADDR_W-1:0] next_pc_o,
    input  logic              inst_ready_i
);
    localparam int IDX_W = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INST_BYTES - 1);

    typedef enum logic {ISSUE, HOLD} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [IDX_W-1:0]    idx;
    logic                tag_vld, tag_last;
    logic [IDX_W-1:0]    tag_idx;
    logic [ADDR_W-1:0]   tag_pc;
    logic [INST_W-1:0]   asm_q, asm_full;
    logic [INST_W-1:0]   q_inst [DEPTH];
    logic [ADDR_W-1:0]   q_pc   [DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count, count_nxt, inflight, inflight_nxt;
    logic                grant, start, last_grant, arrive, push, pop, credit_nxt;

    // Request is forced low while reset is held even though the FSM already sits in ISSUE.
    assign mem_req_o  = rdy && !rst && (state == ISSUE);
    assign mem_addr_o = fetch_pc + ADDR_W'(idx);

    assign grant      = mem_req_o && mem_gnt_i;
    assign start      = grant && (idx == '0);
    assign last_grant = grant && (idx == LAST_IDX);
    assign arrive     = rdy && tag_vld;
    assign push       = arrive && tag_last;
    assign pop        = rdy && inst_valid_o && inst_ready_i;

    always_comb begin
        asm_full = asm_q;
        asm_full[int'(tag_idx)*8 +: 8] = mem_data_i;
    end

    // Credit looks at post-edge occupancy: queued plus started-but-not-pushed instructions.
    assign count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
    assign inflight_nxt = inflight + CNT_W'(start) - CNT_W'(push);
    assign credit_nxt   = (int'(count_nxt) + int'(inflight_nxt)) < DEPTH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ISSUE;
            fetch_pc <= RESET_PC;
            idx      <= '0;
            tag_vld  <= 1'b0;
            tag_last <= 1'b0;
            tag_idx  <= '0;
            tag_pc   <= '0;
            asm_q    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
        end else if (rdy) begin
            if (flush_i) begin
                state    <= ISSUE;
                fetch_pc <= flush_pc_i;
                idx      <= '0;
                tag_vld  <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                inflight <= '0;
            end else begin
                tag_vld <= grant;
                if (grant) begin
                    tag_last <= last_grant;
                    tag_idx  <= idx;
                    tag_pc   <= fetch_pc;
                end
                if (arrive) asm_q <= asm_full;
                if (last_grant) begin
                    idx      <= '0;
                    fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);
                    state    <= credit_nxt ? ISSUE : HOLD;
                end else if (grant) begin
                    idx <= idx + 1'b1;
                end
                if (state == HOLD && credit_nxt) state <= ISSUE;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count    <= count_nxt;
                inflight <= inflight_nxt;
            end
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (rdy && !flush_i && push) begin
            q_inst[wr_ptr] <= asm_full;
            q_pc[wr_ptr]   <= tag_pc;
        end
    end

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? q_inst[rd_ptr] : '0;
    assign inst_pc_o    = inst_valid_o ? q_pc[rd_ptr] : '0;
    assign next_pc_o    = inst_valid_o ? q_pc[rd_ptr] + ADDR_W'(INST_BYTES) : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue: memory returns a[7:0], consumed instructions are
// checked against the expected PC stream (pc, pc+4, ... restarting at each flush target).
module tb_if_prefetch_queue;
    localparam int AW = 32, IB = 4, IW = 32, DEPTH = 4;

    logic          clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush_i = 1'b0;
    logic [AW-1:0] flush_pc_i = '0;
    logic          mem_req_o, mem_gnt_i = 1'b0;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_data_i = '0;
    logic          inst_valid_o, inst_ready_i = 1'b0;
    logic [IW-1:0] inst_o;
    logic [AW-1:0] inst_pc_o, next_pc_o;

    always #5 clk = ~clk;

    if_prefetch_queue #(.ADDR_W(AW), .INST_BYTES(IB), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_data_i(mem_data_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .next_pc_o(next_pc_o), .inst_ready_i(inst_ready_i)
    );

    int checks = 0, errors = 0;
    int n_pop = 0, n_gnt = 0;
    logic [AW-1:0] exp_pc = '0;
    logic mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] ref_inst(input logic [AW-1:0] pc);
        logic [IW-1:0] r;
        for (int k = 0; k < IB; k++) begin
            logic [AW-1:0] a;
            a = pc + AW'(k);
            r[8*k +: 8] = a[7:0];
        end
        return r;
    endfunction

    // Memory: a byte granted in one cycle is presented for the following cycle and held.
    logic          g_pend = 1'b0;
    logic [AW-1:0] g_addr = '0;
    always @(negedge clk) begin
        g_pend = !rst && rdy && mem_req_o && mem_gnt_i;
        g_addr = mem_addr_o;
        if (g_pend) n_gnt++;
    end
    always @(posedge clk) if (g_pend) mem_data_i <= g_addr[7:0];

    // Consumer-side scoreboard.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (!rdy) chk("req_frozen", 32'(mem_req_o), 32'd0);
            if (rdy && !flush_i && inst_valid_o && inst_ready_i) begin
                chk("inst_pc", inst_pc_o, exp_pc);
                chk("inst", inst_o, ref_inst(exp_pc));
                chk("next_pc", next_pc_o, exp_pc + AW'(IB));
                exp_pc = exp_pc + AW'(IB);
                n_pop++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic gnt, input logic ready);
        mon_en = 1'b0; rst = 1'b1; rdy = 1'b1; flush_i = 1'b0;
        mem_gnt_i = gnt; inst_ready_i = ready;
        tick(); tick();
        rst = 1'b0; n_gnt = 0; n_pop = 0; exp_pc = '0; mon_en = 1'b1;
    endtask

    task automatic wait_pops(input int target, input int budget);
        int b = 0;
        while (n_pop < target && b < budget) begin tick(); b++; end
        chk("pop_timeout", 32'(n_pop >= target), 32'd1);
    endtask

    initial begin
        // Scenario 1: reset values and first-instruction latency.
        rst = 1'b1; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        tick();
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", inst_pc_o, 32'd0);
        chk("rst_next", next_pc_o, 32'd0);
        do_reset(1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("lat_req", 32'(mem_req_o), 32'd1);
            chk("lat_addr", mem_addr_o, 32'(c));
            chk("lat_valid", 32'(inst_valid_o), 32'(c == 5));
        end
        chk("lat_inst", inst_o, 32'h03020100);
        chk("lat_next", next_pc_o, 32'd4);
        wait_pops(3, 40);

        // Scenario 2: back-pressure fills the queue, one pop releases one more instruction.
        do_reset(1'b1, 1'b0);
        repeat (40) tick();
        @(negedge clk);
        chk("full_gnts", 32'(n_gnt), 32'(DEPTH * IB));
        chk("full_req", 32'(mem_req_o), 32'd0);
        chk("full_valid", 32'(inst_valid_o), 32'd1);
        tick();
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        @(negedge clk);
        chk("resume_req", 32'(mem_req_o), 32'd1);
        chk("resume_addr", mem_addr_o, 32'd16);
        tick();
        inst_ready_i = 1'b1;
        wait_pops(8, 80);

        // Scenario 3: flush after two granted bytes; stale byte must be dropped.
        do_reset(1'b1, 1'b0);
        tick(); tick();
        flush_i = 1'b1; flush_pc_i = 32'h100; exp_pc = 32'h100;
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(inst_valid_o), 32'd0);
        chk("flush_addr", mem_addr_o, 32'h100);
        tick();
        inst_ready_i = 1'b1;
        wait_pops(3, 40);
        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFF8; exp_pc = 32'hFFFF_FFF8;
        tick();
        flush_i = 1'b0;
        wait_pops(n_pop + 4, 60);

        // Scenario 5: freeze mid-instruction.
        do_reset(1'b1, 1'b1);
        tick(); tick();
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("frz_addr", mem_addr_o, 32'd2);
            chk("frz_valid", 32'(inst_valid_o), 32'd0);
            tick();
        end
        rdy = 1'b1;
        wait_pops(4, 60);

        // Scenario 4: random grant, then random grant/ready/rdy/flush.
        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 200 && n_pop < 10; i++) begin
            mem_gnt_i = 1'($urandom % 2);
            tick();
        end
        chk("rand_gnt_progress", 32'(n_pop >= 10), 32'd1);
        for (int i = 0; i < 800; i++) begin
            rdy          = ($urandom_range(0, 9) != 0);
            mem_gnt_i    = 1'($urandom % 2);
            inst_ready_i = 1'($urandom % 2);
            flush_i      = 1'b0;
            if (rdy && $urandom_range(0, 39) == 0) begin
                flush_i = 1'b1; flush_pc_i = $urandom; exp_pc = flush_pc_i;
            end
            tick();
        end
        rdy = 1'b1; flush_i = 1'b0; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        wait_pops(n_pop + 4, 100);

        // Scenario 6: asynchronous reset mid-fetch.
        do_reset(1'b1, 1'b1);
        repeat (6) tick();
        @(posedge clk);
        #3 rst = 1'b1; mon_en = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req_o), 32'd0);
        chk("arst_addr", mem_addr_o, 32'd0);
        chk("arst_valid", 32'(inst_valid_o), 32'd0);
        chk("arst_inst", inst_o, 32'd0);
        chk("arst_next", next_pc_o, 32'd0);
        tick();
        rst = 1'b0; n_pop = 0; exp_pc = '0; mon_en = 1'b1;
        @(negedge clk);
        chk("arst_restart_addr", mem_addr_o, 32'd0);
        chk("arst_restart_req", 32'(mem_req_o), 32'd1);
        wait_pops(3, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
